dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline's MEM stage (port 0) and the DMA/debug loader (port 1). Each cycle it grants at most one single-word access. It drives the memory's address, write-data and read/write strobes, and routes the registered read data back to the port that issued the read. Port 0 has default priority. A bounded-wait counter guarantees port 1 cannot be starved indefinitely.

## Interface
- ADDR_W, 32, byte-address width; memory word index is addr[9:2] downstream
- DATA_W, 32, data word width
- MAX_WAIT, 4, consecutive lost arbitrations after which port 1 wins; legal range 1..15
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low; clears all state immediately while low
- p0_req  input  1  port 0 access request (MEM stage)
- p0_we  input  1  1 = write, 0 = read
- p0_addr  input  ADDR_W  byte address
- p0_wdata  input  DATA_W  write data
- p0_gnt  output  1  access accepted this cycle (transfer = req & gnt)
- p0_rvalid  output  1  read data valid on p0_rdata this cycle
- p0_rdata  output  DATA_W  read data; 0 when p0_rvalid = 0
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for the loader
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_rdata  input  DATA_W  memory read data; registered in memory, valid the cycle after mem_read

## Operation
- Grant is combinational from the current requests and the registered boost state.
  - Only one requester active: that requester is granted.
  - Both requesters active: port 0 wins unless boost = 1, in which case port 1 wins.
  - No requester active: no grant.
- Memory drive follows the granted port.
  - mem_addr and mem_wdata come from the granted port.
  - mem_write = granted we.
  - mem_read = granted ~we.
  - With no grant, all memory outputs are 0.
- A requester holds req, we, addr and wdata stable until it sees gnt. A request dropped before gnt is withdrawn with no side effects.
- wait_cnt (4 bit) tracks port 1 contention.
  - Increments on each cycle where p1_req = 1 and p1_gnt = 0. It saturates at MAX_WAIT.
  - Clears on a port 1 grant or when p1_req = 0.
  - boost = (wait_cnt == MAX_WAIT).
- State machine view, derived from wait_cnt:
  - P0_PRI: wait_cnt < MAX_WAIT.
  - P1_BOOST: wait_cnt == MAX_WAIT. Exits to P0_PRI on the port 1 grant.
- Read return uses two registered flags, rd_own0 and rd_own1, set at the clock edge that ends a granted read for that port and cleared otherwise.
  - pX_rvalid = rd_ownX.
  - pX_rdata = rd_ownX ? mem_rdata : 0.
- Writes produce no rvalid.
- A new grant is allowed every cycle. Back-to-back reads from alternating ports each return correctly in order.

## Timing
- Asynchronous reset (reset low):
  - wait_cnt, rd_own0 and rd_own1 are 0 immediately.
  - p0_gnt, p1_gnt, mem_read, mem_write, mem_addr and mem_wdata are forced to 0 regardless of requests.
  - Both rvalid outputs are 0 and both rdata outputs are 0.
- Reset mid-read: the pending rvalid is lost. The requester must reissue.
- Grant latency: 0 cycles when uncontended.
- Read latency: request granted in cycle N; rvalid and rdata presented in cycle N+1.
- Write: takes effect at the edge ending cycle N.
- Port 1 worst-case wait under continuous port 0 traffic: MAX_WAIT cycles of lost arbitration, then granted in the following cycle.
- Same address written by port 0 and read by port 1 in consecutive cycles: the read returns the new data. This is ordering by grant sequence.

## Test plan
- Reset hold: assert reset low with both requests active -> all gnt, mem_read, mem_write and rvalid stay 0. Release -> p0_gnt = 1 in the same cycle.
- Port 0 write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> p0_rvalid = 1 one cycle after the read grant, p0_rdata = 0xDEADBEEF, p1_rvalid = 0.
- Contention fairness, MAX_WAIT = 4: p0_req and p1_req held high continuously -> p0 granted 4 cycles, p1 granted on the 5th, pattern repeats.
- Alternating reads: p0 reads 0x20 (holding 0x11), p1 reads 0x24 (holding 0x22) in back-to-back cycles -> p0 rdata 0x11, then p1 rdata 0x22, each with only its own rvalid set.
- Withdrawal: p1_req dropped after 3 lost cycles -> wait_cnt returns to 0. Re-request under contention takes 4 more losses before grant.
- Async reset asserted in the cycle after a granted p1 read -> p1_rvalid = 0 immediately and stays 0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port single-word arbiter for the shared data memory: port 0 (MEM stage) has
// default priority; port 1 (loader) is boosted after MAX_WAIT consecutive losses.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {P0_PRI, P1_BOOST} arb_state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_cnt_next;
  logic       r_rd_own0;
  logic       r_rd_own1;
  arb_state_t w_state;
  logic       w_gnt0;
  logic       w_gnt1;

  // Grants are gated by reset so nothing reaches the memory while it is held low.
  always_comb begin
    w_state = (r_wait_cnt == MAX_WAIT_C) ? P1_BOOST : P0_PRI;
    w_gnt1  = reset & p1_req & (~p0_req | (w_state == P1_BOOST));
    w_gnt0  = reset & p0_req & ~w_gnt1;

    w_wait_cnt_next = r_wait_cnt;
    if (!p1_req || w_gnt1) begin
      w_wait_cnt_next = 4'd0;
    end else if (r_wait_cnt < MAX_WAIT_C) begin
      w_wait_cnt_next = r_wait_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (w_gnt0) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_write = p0_we;
      mem_read  = ~p0_we;
    end else if (w_gnt1) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_write = p1_we;
      mem_read  = ~p1_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 4'd0;
      r_rd_own0  <= 1'b0;
      r_rd_own1  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_next;
      r_rd_own0  <= w_gnt0 & ~p0_we;
      r_rd_own1  <= w_gnt1 & ~p1_we;
    end
  end

  // Memory read data is registered downstream, so ownership flags line it up.
  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign p0_rvalid = r_rd_own0;
  assign p1_rvalid = r_rd_own1;
  assign p0_rdata  = r_rd_own0 ? mem_rdata : '0;
  assign p1_rdata  = r_rd_own1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for reset and
// fairness, and randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-ported memory device with registered read.
  logic [31:0] dev_mem [256];
  always @(posedge clk) begin
    if (mem_write) dev_mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dev_mem[mem_addr[9:2]];
  end

  // Reference model state: word store, pending read returns, port 1 loss streak.
  logic [31:0] ref_mem [256];
  int          ref_losses;
  logic        ref_rv0, ref_rv1;
  logic [31:0] ref_rd0, ref_rd1;

  logic        s_g0, s_g1, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the currently driven inputs: compare at the falling
  // edge, advance the model at the rising edge, return 1 time unit later.
  task automatic cycle();
    logic        e_g0, e_g1, e_mr, e_mw;
    logic [31:0] e_a, e_d;
    @(negedge clk);
    e_g1 = reset && p1_req && (!p0_req || ref_losses >= MAX_WAIT);
    e_g0 = reset && p0_req && !e_g1;
    e_a = 32'h0; e_d = 32'h0; e_mr = 1'b0; e_mw = 1'b0;
    if (e_g0) begin
      e_a = p0_addr; e_d = p0_wdata; e_mw = p0_we; e_mr = !p0_we;
    end else if (e_g1) begin
      e_a = p1_addr; e_d = p1_wdata; e_mw = p1_we; e_mr = !p1_we;
    end
    s_g0 = p0_gnt; s_g1 = p1_gnt; s_rv0 = p0_rvalid; s_rv1 = p1_rvalid;
    s_rd0 = p0_rdata; s_rd1 = p1_rdata;
    chk1("p0_gnt", p0_gnt, e_g0);
    chk1("p1_gnt", p1_gnt, e_g1);
    chk1("mem_read", mem_read, e_mr);
    chk1("mem_write", mem_write, e_mw);
    chk32("mem_addr", mem_addr, e_a);
    chk32("mem_wdata", mem_wdata, e_d);
    chk1("p0_rvalid", p0_rvalid, ref_rv0);
    chk1("p1_rvalid", p1_rvalid, ref_rv1);
    chk32("p0_rdata", p0_rdata, ref_rv0 ? ref_rd0 : 32'h0);
    chk32("p1_rdata", p1_rdata, ref_rv1 ? ref_rd1 : 32'h0);
    if (e_g0 || e_g1)
      $display("t=%0t xfer p%0d %s addr=%h wdata=%h", $time, e_g1 ? 1 : 0,
               e_mw ? "WR" : "RD", e_a, e_d);
    @(posedge clk);
    if (!reset) begin
      ref_losses = 0; ref_rv0 = 1'b0; ref_rv1 = 1'b0;
    end else begin
      ref_rv0 = e_g0 && !p0_we;
      ref_rv1 = e_g1 && !p1_we;
      if (ref_rv0) ref_rd0 = ref_mem[p0_addr[9:2]];
      if (ref_rv1) ref_rd1 = ref_mem[p1_addr[9:2]];
      if (e_g0 && p0_we) ref_mem[p0_addr[9:2]] = p0_wdata;
      if (e_g1 && p1_we) ref_mem[p1_addr[9:2]] = p1_wdata;
      if (p1_req && !e_g1) ref_losses = (ref_losses < MAX_WAIT) ? ref_losses + 1 : MAX_WAIT;
      else ref_losses = 0;
    end
    #1;
  endtask

  task automatic drive(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                       logic r1, logic w1, logic [31:0] a1, logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic rv0, logic rv1,
                              logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    tbl[0] = mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 32'h10, 0,            0, 0, 0, 0,          1, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0,                 0, 0, 0, 0,          0, 0, 1, 0, 32'hDEADBEEF, 0);
    tbl[3] = mk(1, 1, 32'h20, 32'h11,       0, 0, 0, 0,          1, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 0, 0,                 1, 1, 32'h24, 32'h22, 0, 1, 0, 0, 0, 0);
    tbl[5] = mk(1, 0, 32'h20, 0,            0, 0, 0, 0,          1, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 0,                 1, 0, 32'h24, 0,     0, 1, 1, 0, 32'h11, 0);
    tbl[7] = mk(0, 0, 0, 0,                 0, 0, 0, 0,          0, 0, 0, 1, 0, 32'h22);
    tbl[8] = mk(1, 0, 32'h10, 0,            1, 1, 32'h28, 32'h33, 1, 0, 0, 0, 0, 0);
    tbl[9] = mk(0, 0, 0, 0,                 0, 0, 0, 0,          0, 0, 1, 0, 32'hDEADBEEF, 0);

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_losses = 0; ref_rv0 = 1'b0; ref_rv1 = 1'b0; ref_rd0 = 32'h0; ref_rd1 = 32'h0;

    // Reset hold with both ports requesting, then release.
    reset = 1'b0;
    drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk1("rst_hold_g0", s_g0, 1'b0);
      chk1("rst_hold_g1", s_g1, 1'b0);
      chk1("rst_hold_rv", s_rv0 | s_rv1, 1'b0);
    end
    reset = 1'b1;
    drive(1, 1, 32'h40, 32'h0, 0, 0, 0, 0);
    cycle();
    chk1("rst_release_g0", s_g0, 1'b1);

    // Preload the random-traffic region so every read has a known value.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 32'h40 + 32'(4 * i), $urandom, 0, 0, 0, 0);
      cycle();
    end

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      cycle();
      chk1("vec_g0", s_g0, tbl[i].g0);
      chk1("vec_g1", s_g1, tbl[i].g1);
      chk1("vec_rv0", s_rv0, tbl[i].rv0);
      chk1("vec_rv1", s_rv1, tbl[i].rv1);
      chk32("vec_rd0", s_rd0, tbl[i].rd0);
      chk32("vec_rd1", s_rd1, tbl[i].rd1);
    end

    // Contention: p1 wins once every MAX_WAIT+1 cycles.
    drive(1, 0, 32'h48, 0, 1, 0, 32'h4C, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk1("fair_p1_gnt", s_g1, (i % 5) == 4);
    end

    // Withdrawal after 3 losses restarts the loss count.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 32'h50, 32'h5A5A, 1, 0, 32'h54, 0);
    for (int i = 0; i < 3; i++) cycle();
    p1_req = 1'b0;
    cycle();
    p1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk1("withdraw_p1_gnt", s_g1, i == 4);
    end

    // Reset asserted while a p1 read return is pending.
    drive(0, 0, 0, 0, 1, 0, 32'h24, 0);
    cycle();
    chk1("pre_rst_rd_g1", s_g1, 1'b1);
    chk1("pre_rst_rvalid", p1_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rst_mid_rvalid", p1_rvalid, 1'b0);
    chk32("rst_mid_rdata", p1_rdata, 32'h0);
    ref_rv1 = 1'b0; ref_losses = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b1;
    cycle();
    chk1("rst_after_rvalid", s_rv1, 1'b0);

    // Randomized traffic; a refused requester keeps its request stable.
    for (int n = 0; n < 400; n++) begin
      if (!(p0_req && !s_g0)) begin
        p0_req = 1'($urandom_range(0, 2) != 0); p0_we = 1'($urandom_range(0, 1));
        p0_addr = 32'h40 + 32'(4 * $urandom_range(0, 15)); p0_wdata = $urandom;
      end
      if (!(p1_req && !s_g1)) begin
        p1_req = 1'($urandom_range(0, 2) != 0); p1_we = 1'($urandom_range(0, 1));
        p1_addr = 32'h40 + 32'(4 * $urandom_range(0, 15)); p1_wdata = $urandom;
      end
      cycle();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
